button_event_detector: RTL and testbench
========================================

# button_event_detector

Consumes the clean, synchronous level from the switch debouncer and turns it into single-cycle user-interface events: press, release, single click, double click, long press and auto-repeat. It sits directly downstream of the debouncer and upstream of the control/CSR logic. Its input must already be synchronised and debounced; the block applies no further synchronisation or filtering.

## Interface
- IS_PULLUP, 0: polarity of i_sig_debounced. 0 means 1 = pressed; 1 means 0 = pressed. Internal level lvl = i_sig_debounced XOR IS_PULLUP.
- LONG_CYCLES, 16: consecutive pressed samples that qualify a long press. Must be ≥ 2.
- DCLICK_CYCLES, 8: double-click window, in released samples. Must be ≥ 2.
- REPEAT_CYCLES, 4: auto-repeat period, in pressed samples after a long press. Must be ≥ 1.
- REPEAT_EN, 1: 1 enables o_repeat; 0 ties o_repeat low.
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- i_sig_debounced  input  1  debounced switch level, synchronous to clk.
- o_press  output  1  one-cycle pulse on each pressed edge.
- o_release  output  1  one-cycle pulse on each released edge.
- o_single  output  1  one-cycle pulse when a single click is classified.
- o_double  output  1  one-cycle pulse when a double click is classified.
- o_long  output  1  one-cycle pulse when a long press qualifies.
- o_repeat  output  1  one-cycle pulse on each auto-repeat tick.
- o_held  output  1  level, high while the FSM is in HOLD.

## Operation
- prev_rg holds the previous lvl and resets to 0 (released).
  - rise = lvl & ~prev_rg
  - fall = ~lvl & prev_rg
- o_press = registered rise. o_release = registered fall. Both are independent of FSM state.
- Timer cnt is unsigned, width $clog2(max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES)) + 1. It saturates and never wraps.
- On a rise or fall, cnt loads 1, so the edge sample counts as sample 1.
- FSM states and transitions, evaluated on each sample:
  - IDLE: cnt = 0. Rise → PRESS1.
  - PRESS1:
    - Fall → WAIT2.
    - LONG_CYCLES-th consecutive pressed sample → pulse o_long, go to HOLD, cnt = 0.
  - HOLD:
    - Each REPEAT_CYCLES-th pressed sample after the long sample → pulse o_repeat, cnt restarts.
    - Fall → IDLE, with no click reported.
  - WAIT2:
    - Rise before the DCLICK_CYCLES-th released sample → PRESS2.
    - DCLICK_CYCLES-th consecutive released sample (fall sample included) → pulse o_single, go to IDLE.
  - PRESS2:
    - Fall → pulse o_double, go to IDLE.
    - LONG_CYCLES-th consecutive pressed sample → pulse o_single and o_long in the same cycle, go to HOLD.
- Simultaneous events:
  - o_release and o_double pulse in the same cycle.
  - o_press and the PRESS2 entry coincide; no click pulse is emitted at that point.
- A third press after a double click starts a new sequence from IDLE.
- All event outputs are registered and every pulse is exactly 1 cycle wide.

## Timing
- Event latency: 1 cycle. A pulse appears in the cycle after the clock edge at which the qualifying sample is taken.
- Reset values while rstn is low and in the first cycle after release:
  - all outputs 0
  - FSM = IDLE
  - cnt = 0
  - prev_rg = 0
- Reset mid-operation aborts any pending classification. No pulse from before the reset may appear after it.
- A switch held pressed across reset release is treated as a new press. o_press pulses 1 cycle after the first sample taken after reset.
- Minimum throughput: consecutive rise and fall one cycle apart, i.e. a 1-sample press, must still produce o_press, o_release and correct classification.
- If REPEAT_EN = 0, HOLD behaves identically except that o_repeat stays low.

## Test plan
All scenarios use defaults (LONG_CYCLES 16, DCLICK_CYCLES 8, REPEAT_CYCLES 4), with sample 1 = first changed sample.
- **Single click:** high 5 samples, then low 20.
  - o_press after high sample 1; o_release after low sample 1.
  - o_single after low sample 8 only; no o_double, no o_long.
- **Double click:** high 3, low 5, high 3, low 10.
  - Two o_press and two o_release pulses.
  - o_double coincides with the second o_release.
  - o_single never pulses.
- **Window edge:** high 3, low 7, high 3 → o_double. High 3, low 8, high 3 → o_single after low sample 8, and the second press starts a new sequence.
- **Long press and repeat:** high 30, then low.
  - o_long after high sample 16; o_held high from the next cycle.
  - o_repeat after high samples 20, 24, 28.
  - o_release on the fall, with no click pulses.
  - With REPEAT_EN = 0, no o_repeat pulses.
- **Click then long:** high 2, low 3, high 20.
  - o_single and o_long pulse together after high sample 16 of the second press; no o_double.
- **Reset mid-sequence and pull-up:**
  - Assert rstn low during WAIT2 → all outputs 0 and no later o_single.
  - Hold input pressed through reset release → o_press 1 cycle after the first post-reset sample.
  - With IS_PULLUP = 1, repeat the single-click scenario with inverted input → identical pulses.

Source files
------------

// File: rtl/button_event_detector_if.sv
// Debounced button level in, single-cycle UI events out.
// master = event detector, slave = the level source / event consumer.
interface button_event_detector_if;
    logic i_sig_debounced;
    logic o_press;
    logic o_release;
    logic o_single;
    logic o_double;
    logic o_long;
    logic o_repeat;
    logic o_held;

    modport master (
        input  i_sig_debounced,
        output o_press, o_release, o_single, o_double, o_long, o_repeat, o_held
    );

    modport slave (
        output i_sig_debounced,
        input  o_press, o_release, o_single, o_double, o_long, o_repeat, o_held
    );
endinterface

// File: rtl/button_event_detector.sv
// Classifies a debounced button level into press/release/click/double/long/repeat pulses.
// Latency 1 cycle from the qualifying sample; no backpressure, every sample is consumed.
module button_event_detector #(
    parameter bit IS_PULLUP     = 1'b0,
    parameter int LONG_CYCLES   = 16,
    parameter int DCLICK_CYCLES = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter bit REPEAT_EN     = 1'b1
) (
    input logic                     clk,
    input logic                     rstn,
    button_event_detector_if.master bus
);

    localparam int MAX_LD = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
    localparam int MAX_ALL = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
    localparam int CW = $clog2(MAX_ALL) + 1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        HOLD,
        WAIT2,
        PRESS2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            prev_q, prev_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            single_q, single_d;
    logic            double_q, double_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;
    logic            held_q, held_d;

    logic            lvl;
    logic            rise;
    logic            fall;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   cnt_nxt;

    assign lvl  = bus.i_sig_debounced ^ IS_PULLUP;
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

    // Edge sample counts as sample 1 of the new phase; otherwise count up, saturating.
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign cnt_nxt = (rise | fall) ? CW'(1) : cnt_inc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_nxt;
        prev_d    = lvl;
        press_d   = rise;
        release_d = fall;
        single_d  = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = PRESS1;
                    cnt_d   = CW'(1);
                end
            end
            PRESS1: begin
                if (fall) begin
                    state_d = WAIT2;
                end else if (cnt_nxt == CW'(LONG_CYCLES)) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_nxt == CW'(REPEAT_CYCLES)) begin
                    repeat_d = REPEAT_EN;
                    cnt_d    = '0;
                end
            end
            WAIT2: begin
                if (rise) begin
                    state_d = PRESS2;
                end else if (cnt_nxt == CW'(DCLICK_CYCLES)) begin
                    single_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
            end
            PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_nxt == CW'(LONG_CYCLES)) begin
                    // The earlier click was never paired, so it resolves as a single here.
                    single_d = 1'b1;
                    long_d   = 1'b1;
                    state_d  = HOLD;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            press_q   <= press_d;
            release_q <= release_d;
            single_q  <= single_d;
            double_q  <= double_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign bus.o_press   = press_q;
    assign bus.o_release = release_q;
    assign bus.o_single  = single_q;
    assign bus.o_double  = double_q;
    assign bus.o_long    = long_q;
    assign bus.o_repeat  = repeat_q;
    assign bus.o_held    = held_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Directed bench for button_event_detector: default, no-repeat and pull-up instances
// run side by side; per-sample event histories are compared against hand-built masks.
module tb_button_event_detector;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_SINGLE  = 2;
    localparam int EV_DOUBLE  = 3;
    localparam int EV_LONG    = 4;
    localparam int EV_REPEAT  = 5;
    localparam int EV_HELD    = 6;

    logic clk;
    logic rstn;

    button_event_detector_if if_def ();
    button_event_detector_if if_nr ();
    button_event_detector_if if_pu ();

    button_event_detector u_dut_def (
        .clk (clk),
        .rstn(rstn),
        .bus (if_def)
    );

    button_event_detector #(.REPEAT_EN(1'b0)) u_dut_nr (
        .clk (clk),
        .rstn(rstn),
        .bus (if_nr)
    );

    button_event_detector #(.IS_PULLUP(1'b1)) u_dut_pu (
        .clk (clk),
        .rstn(rstn),
        .bus (if_pu)
    );

    logic [6:0] obs [3];
    assign obs[0] = {if_def.o_held, if_def.o_repeat, if_def.o_long, if_def.o_double,
                     if_def.o_single, if_def.o_release, if_def.o_press};
    assign obs[1] = {if_nr.o_held, if_nr.o_repeat, if_nr.o_long, if_nr.o_double,
                     if_nr.o_single, if_nr.o_release, if_nr.o_press};
    assign obs[2] = {if_pu.o_held, if_pu.o_repeat, if_pu.o_long, if_pu.o_double,
                     if_pu.o_single, if_pu.o_release, if_pu.o_press};

    string ev_name [7] = '{"press", "release", "single", "double", "long", "repeat", "held"};

    int          checks = 0;
    int          errors = 0;
    int          sidx   = 0;
    logic [63:0] hist [3][7];
    logic [63:0] e [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] m(input int p);
        logic [63:0] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] r;
        r = '0;
        for (int i = a; i <= b; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic set_in(input bit v);
        if_def.i_sig_debounced = v;
        if_nr.i_sig_debounced  = v;
        if_pu.i_sig_debounced  = ~v;
    endtask

    task automatic clear_hist();
        sidx = 0;
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) hist[k][ev] = '0;
        for (int ev = 0; ev < 7; ev++) e[ev] = '0;
    endtask

    // Drive n samples of level v; after each sample record which outputs fired.
    task automatic run(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(v);
            @(negedge clk);
            sidx++;
            for (int k = 0; k < 3; k++)
                for (int ev = 0; ev < 7; ev++)
                    if (obs[k][ev] === 1'b1 && sidx < 64) hist[k][ev][sidx] = 1'b1;
        end
    endtask

    task automatic do_reset(input bit v);
        set_in(v);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1'b0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 7'd0) begin
                errors++;
                $display("FAIL reset_low inst%0d got %b want %b", k, obs[k], 7'd0);
            end
        end
        rstn = 1'b1;
        clear_hist();
        run(1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 7'd0) begin
                errors++;
                $display("FAIL reset_first_cycle inst%0d got %b want %b", k, obs[k], 7'd0);
            end
        end
    endtask

    task automatic test_single_click();
        do_reset(1'b0);
        clear_hist();
        run(1'b1, 5);
        run(1'b0, 20);
        e[EV_PRESS]   = m(1);
        e[EV_RELEASE] = m(6);
        e[EV_SINGLE]  = m(13);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL single_click inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end
    endtask

    task automatic test_double_click();
        do_reset(1'b0);
        clear_hist();
        run(1'b1, 3);
        run(1'b0, 5);
        run(1'b1, 3);
        run(1'b0, 10);
        e[EV_PRESS]   = m(1) | m(9);
        e[EV_RELEASE] = m(4) | m(12);
        e[EV_DOUBLE]  = m(12);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL double_click inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end
    endtask

    task automatic test_window_edge();
        do_reset(1'b0);
        clear_hist();
        run(1'b1, 3);
        run(1'b0, 7);
        run(1'b1, 3);
        run(1'b0, 10);
        e[EV_PRESS]   = m(1) | m(11);
        e[EV_RELEASE] = m(4) | m(14);
        e[EV_DOUBLE]  = m(14);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL window_in inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end

        do_reset(1'b0);
        clear_hist();
        run(1'b1, 3);
        run(1'b0, 8);
        run(1'b1, 3);
        run(1'b0, 10);
        e[EV_PRESS]   = m(1) | m(12);
        e[EV_RELEASE] = m(4) | m(15);
        e[EV_SINGLE]  = m(11) | m(22);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL window_out inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end
    endtask

    task automatic test_long_repeat();
        do_reset(1'b0);
        clear_hist();
        run(1'b1, 30);
        run(1'b0, 10);
        e[EV_PRESS]   = m(1);
        e[EV_RELEASE] = m(31);
        e[EV_LONG]    = m(16);
        e[EV_REPEAT]  = m(20) | m(24) | m(28);
        e[EV_HELD]    = rng(16, 30);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL long_repeat inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end
    endtask

    task automatic test_click_then_long();
        do_reset(1'b0);
        clear_hist();
        run(1'b1, 2);
        run(1'b0, 3);
        run(1'b1, 20);
        run(1'b0, 10);
        e[EV_PRESS]   = m(1) | m(6);
        e[EV_RELEASE] = m(3) | m(26);
        e[EV_SINGLE]  = m(21);
        e[EV_LONG]    = m(21);
        e[EV_REPEAT]  = m(25);
        e[EV_HELD]    = rng(21, 25);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL click_then_long inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        clear_hist();
        run(1'b1, 1);
        run(1'b0, 1);
        run(1'b1, 1);
        run(1'b0, 10);
        run(1'b1, 1);
        run(1'b0, 10);
        e[EV_PRESS]   = m(1) | m(3) | m(14);
        e[EV_RELEASE] = m(2) | m(4) | m(15);
        e[EV_DOUBLE]  = m(4);
        e[EV_SINGLE]  = m(22);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL back_to_back inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        clear_hist();
        run(1'b1, 3);
        run(1'b0, 3);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 7'd0) begin
                errors++;
                $display("FAIL reset_mid_low inst%0d got %b want %b", k, obs[k], 7'd0);
            end
        end
        rstn = 1'b1;
        run(1'b0, 15);
        e[EV_PRESS]   = m(1);
        e[EV_RELEASE] = m(4);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL reset_mid inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end
    endtask

    task automatic test_held_through_reset();
        set_in(1'b1);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 7'd0) begin
                errors++;
                $display("FAIL held_reset_low inst%0d got %b want %b", k, obs[k], 7'd0);
            end
        end
        rstn = 1'b1;
        clear_hist();
        run(1'b1, 3);
        run(1'b0, 10);
        e[EV_PRESS]   = m(1);
        e[EV_RELEASE] = m(4);
        e[EV_SINGLE]  = m(11);
        for (int k = 0; k < 3; k++)
            for (int ev = 0; ev < 7; ev++) begin
                checks++;
                if (hist[k][ev] !== ((k == 1 && ev == EV_REPEAT) ? 64'd0 : e[ev])) begin
                    errors++;
                    $display("FAIL held_through_reset inst%0d %s got %h want %h", k, ev_name[ev], hist[k][ev], e[ev]);
                end
            end
    endtask

    initial begin
        rstn = 1'b0;
        set_in(1'b0);
        test_reset();
        test_single_click();
        test_double_click();
        test_window_edge();
        test_long_repeat();
        test_click_then_long();
        test_back_to_back();
        test_reset_mid();
        test_held_through_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
